// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // Header is a 16-bit little-endian word count
    localparam int HDR_BYTES  = 2;
    // Each instruction word arrives as four little-endian bytes
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input, instruction-memory write port and core control of the loader.
interface instr_loader_if;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        InstrWrite;
    logic [31:0] WriteInst;
    logic [31:0] WriteAdress;
    logic        core_reset;
    logic        done;
    logic        error;

    // Host side: supplies the program stream and observes the loader
    modport master (
        output load_start, byte_valid, byte_data,
        input  byte_ready, InstrWrite, WriteInst, WriteAdress, core_reset, done, error
    );

    // Loader side
    modport slave (
        input  load_start, byte_valid, byte_data,
        output byte_ready, InstrWrite, WriteInst, WriteAdress, core_reset, done, error
    );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte-to-word shift register with a 2-bit byte position counter.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // Newest byte enters at the top so the first byte ends up in bits [7:0]
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (shift_i) begin
            word_d = {byte_i, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // Shift register and byte counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= 32'd0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (cnt_q == LAST_BYTE);
endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian program stream into instruction memory
// while holding the core in reset.
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    instr_loader_if.slave bus
);
    state_t      state_q, state_d;
    logic [7:0]  hdr_lo_q;
    logic [15:0] count_q;
    logic [31:0] word_idx_q;
    logic [31:0] inst_q;
    logic [31:0] addr_q;

    logic        byte_ready_c, instr_write_c, core_reset_c, done_c, error_c;
    logic        fire;
    logic        start_load;
    logic [31:0] hdr_n;
    logic [31:0] cur_addr;
    logic [31:0] asm_word;
    logic        asm_full;

    assign fire       = bus.byte_valid && byte_ready_c;
    assign start_load = bus.load_start && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign hdr_n      = {16'd0, bus.byte_data, hdr_lo_q};
    assign cur_addr   = BASE_ADDR + {word_idx_q[29:0], 2'b00};

    word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_load),
        .shift_i     (fire && (state_q == ST_DATA)),
        .byte_i      (bus.byte_data),
        .word_o      (asm_word),
        .word_full_o (asm_full)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_HDR_LO;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR_LO: if (fire) state_d = ST_HDR_HI;
            ST_HDR_HI: begin
                if (fire) begin
                    if (hdr_n == 32'd0)                   state_d = ST_DONE;
                    else if (hdr_n > 32'(DEPTH_WORDS))    state_d = ST_ERR;
                    else                                  state_d = ST_DATA;
                end
            end
            ST_DATA:   if (fire && asm_full) state_d = ST_WRITE;
            ST_WRITE:  begin
                if ((word_idx_q + 32'd1) < {16'd0, count_q}) state_d = ST_DATA;
                else                                          state_d = ST_DONE;
            end
            ST_DONE,
            ST_ERR:    if (bus.load_start) state_d = ST_HDR_LO;
            default:   state_d = ST_HDR_LO;
        endcase
    end

    // Per-state control outputs
    always_comb begin
        byte_ready_c  = 1'b0;
        instr_write_c = 1'b0;
        core_reset_c  = 1'b1;
        done_c        = 1'b0;
        error_c       = 1'b0;
        case (state_q)
            ST_HDR_LO, ST_HDR_HI, ST_DATA: byte_ready_c  = 1'b1;
            ST_WRITE:                      instr_write_c = 1'b1;
            ST_DONE: begin
                core_reset_c = 1'b0;
                done_c       = 1'b1;
            end
            ST_ERR:                        error_c       = 1'b1;
            default: ;
        endcase
    end

    // Header capture, word index and held write-bus values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_lo_q   <= 8'd0;
            count_q    <= 16'd0;
            word_idx_q <= 32'd0;
            inst_q     <= 32'd0;
            addr_q     <= BASE_ADDR;
        end else begin
            if (fire && (state_q == ST_HDR_LO)) hdr_lo_q <= bus.byte_data;
            if (fire && (state_q == ST_HDR_HI)) count_q  <= hdr_n[15:0];
            if (start_load) begin
                word_idx_q <= 32'd0;
            end else if (state_q == ST_WRITE) begin
                word_idx_q <= word_idx_q + 32'd1;
                inst_q     <= asm_word;
                addr_q     <= cur_addr;
            end
        end
    end

    // The write bus shows the live word during WRITE and holds it afterwards
    assign bus.WriteInst   = instr_write_c ? asm_word : inst_q;
    assign bus.WriteAdress = instr_write_c ? cur_addr : addr_q;
    assign bus.byte_ready  = byte_ready_c;
    assign bus.InstrWrite  = instr_write_c;
    assign bus.core_reset  = core_reset_c;
    assign bus.done        = done_c;
    assign bus.error       = error_c;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench: two loaders (base 0x0 and 0x100) driven by one shared stream.
module tb_instr_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] wa_a[$], wd_a[$], wa_b[$], wd_b[$];
    int  lat_bad = 0;
    int  cr_bad = 0;
    bit  track_cr = 1'b0;
    bit  fire_prev = 1'b0;
    logic [7:0] stream [10];

    instr_loader_if bus_a ();
    instr_loader_if bus_b ();

    assign bus_a.load_start = load_start;
    assign bus_a.byte_valid = byte_valid;
    assign bus_a.byte_data  = byte_data;
    assign bus_b.load_start = load_start;
    assign bus_b.byte_valid = byte_valid;
    assign bus_b.byte_data  = byte_data;

    instr_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    instr_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h100)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus_a.InstrWrite === 1'b1) begin
            wa_a.push_back(bus_a.WriteAdress);
            wd_a.push_back(bus_a.WriteInst);
            if (!fire_prev) lat_bad++;
            $display("WRITE A cyc=%0d addr=0x%08h data=0x%08h", cyc, bus_a.WriteAdress, bus_a.WriteInst);
        end
        if (bus_b.InstrWrite === 1'b1) begin
            wa_b.push_back(bus_b.WriteAdress);
            wd_b.push_back(bus_b.WriteInst);
            $display("WRITE B cyc=%0d addr=0x%08h data=0x%08h", cyc, bus_b.WriteAdress, bus_b.WriteInst);
        end
        fire_prev = (bus_a.byte_valid === 1'b1) && (bus_a.byte_ready === 1'b1);
        if (track_cr && (bus_b.core_reset !== 1'b1)) cr_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns just after the edge that accepts it
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        rdy = 1'b0;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            @(negedge clk);
            rdy = bus_a.byte_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        chk("byte_accept", {31'd0, rdy}, 32'd1);
        $display("BYTE 0x%02h accepted cyc=%0d", b, cyc);
    endtask

    task automatic send_stream(input bit gap, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(stream[i]);
            if (gap) begin
                byte_valid = 1'b0;
                tick(1);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        byte_valid = 1'b0;
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    task automatic clear_writes();
        wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    endtask

    // Checks the two-word program landed at base and base+4 on both loaders
    task automatic check_two_words(input string tag);
        chk({tag, "_nA"}, 32'(wa_a.size()), 32'd2);
        chk({tag, "_nB"}, 32'(wa_b.size()), 32'd2);
        if (wa_a.size() == 2) begin
            chk({tag, "_dA0"}, wd_a[0], 32'h0000_0013);
            chk({tag, "_aA0"}, wa_a[0], 32'h0000_0000);
            chk({tag, "_dA1"}, wd_a[1], 32'h0010_0093);
            chk({tag, "_aA1"}, wa_a[1], 32'h0000_0004);
        end
        if (wa_b.size() == 2) begin
            chk({tag, "_dB0"}, wd_b[0], 32'h0000_0013);
            chk({tag, "_aB0"}, wa_b[0], 32'h0000_0100);
            chk({tag, "_dB1"}, wd_b[1], 32'h0010_0093);
            chk({tag, "_aB1"}, wa_b[1], 32'h0000_0104);
        end
    endtask

    initial begin
        stream[0] = 8'h02; stream[1] = 8'h00;
        stream[2] = 8'h13; stream[3] = 8'h00; stream[4] = 8'h00; stream[5] = 8'h00;
        stream[6] = 8'h93; stream[7] = 8'h00; stream[8] = 8'h10; stream[9] = 8'h00;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_ready",  {31'd0, bus_a.byte_ready}, 32'd1);
        chk("rst_iw",     {31'd0, bus_a.InstrWrite}, 32'd0);
        chk("rst_wi",     bus_a.WriteInst, 32'd0);
        chk("rst_waA",    bus_a.WriteAdress, 32'h0);
        chk("rst_waB",    bus_b.WriteAdress, 32'h100);
        chk("rst_corer",  {31'd0, bus_a.core_reset}, 32'd1);
        chk("rst_done",   {31'd0, bus_a.done}, 32'd0);
        chk("rst_error",  {31'd0, bus_a.error}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick(1);

        // Two-word program with valid held high
        clear_writes();
        lat_bad = 0;
        send_stream(1'b0, 10);
        tick(2);
        check_two_words("held");
        chk("held_lat",   32'(lat_bad), 32'd0);
        chk("held_done",  {31'd0, bus_a.done}, 32'd1);
        chk("held_corer", {31'd0, bus_a.core_reset}, 32'd0);
        chk("held_ready", {31'd0, bus_a.byte_ready}, 32'd0);
        chk("hold_wi",    bus_a.WriteInst, 32'h0010_0093);
        chk("hold_wa",    bus_b.WriteAdress, 32'h104);

        // Reload from DONE: core stays in reset throughout
        clear_writes();
        pulse_start();
        track_cr = 1'b1;
        cr_bad = 0;
        chk("reld_done",  {31'd0, bus_b.done}, 32'd0);
        chk("reld_ready", {31'd0, bus_b.byte_ready}, 32'd1);
        send_stream(1'b0, 10);
        tick(1);
        track_cr = 1'b0;
        chk("reld_cr",    32'(cr_bad), 32'd0);
        tick(1);
        check_two_words("reld");
        chk("reld_fin",   {31'd0, bus_b.done}, 32'd1);

        // Same program with a valid gap after every byte
        clear_writes();
        lat_bad = 0;
        pulse_start();
        send_stream(1'b1, 10);
        tick(2);
        check_two_words("gap");
        chk("gap_lat",    32'(lat_bad), 32'd0);
        chk("gap_done",   {31'd0, bus_a.done}, 32'd1);

        // Empty program: DONE straight after the header
        clear_writes();
        pulse_start();
        stream[0] = 8'h00; stream[1] = 8'h00;
        send_stream(1'b0, 2);
        chk("empty_done", {31'd0, bus_a.done}, 32'd1);
        chk("empty_cr",   {31'd0, bus_a.core_reset}, 32'd0);
        tick(2);
        chk("empty_nw",   32'(wa_a.size()), 32'd0);

        // Oversized header (257 words) lands in ERR
        pulse_start();
        stream[0] = 8'h01; stream[1] = 8'h01;
        send_stream(1'b0, 2);
        tick(1);
        chk("err_error",  {31'd0, bus_a.error}, 32'd1);
        chk("err_ready",  {31'd0, bus_a.byte_ready}, 32'd0);
        chk("err_cr",     {31'd0, bus_a.core_reset}, 32'd1);
        chk("err_done",   {31'd0, bus_a.done}, 32'd0);
        chk("err_nw",     32'(wa_a.size()), 32'd0);
        load_start = 1'b0;

        // Restart from ERR, abandon mid-load with reset, then resend
        stream[0] = 8'h02; stream[1] = 8'h00;
        pulse_start();
        chk("errx_error", {31'd0, bus_a.error}, 32'd0);
        send_stream(1'b0, 5);
        reset = 1'b0;
        #1;
        chk("mrst_ready", {31'd0, bus_a.byte_ready}, 32'd1);
        chk("mrst_cr",    {31'd0, bus_a.core_reset}, 32'd1);
        chk("mrst_wa",    bus_b.WriteAdress, 32'h100);
        tick(1);
        reset = 1'b1;
        tick(1);
        clear_writes();
        send_stream(1'b0, 10);
        tick(2);
        check_two_words("mrst");
        chk("mrst_done",  {31'd0, bus_a.done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256: number of instruction-memory words available.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0: byte address of the first word written.
REQ-003 The block SHALL have port clk  input  1  the single clock; every flop is posedge clk.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load_start  input  1  one-cycle pulse that starts a new load from DONE or ERR.
REQ-006 The block SHALL have port byte_valid  input  1  the source presents byte_data.
REQ-007 The block SHALL have port byte_data  input  8  the program stream byte.
REQ-008 The block SHALL have port byte_ready  output  1  the block accepts a byte this cycle.
REQ-009 The block SHALL have port InstrWrite  output  1  instruction-memory write strobe.
REQ-010 The block SHALL have port WriteInst  output  32  instruction word to write.
REQ-011 The block SHALL have port WriteAdress  output  32  byte address of the write.
REQ-012 The block SHALL have port core_reset  output  1  active-high reset to the core, held while loading.
REQ-013 The block SHALL have port done  output  1  load completed successfully.
REQ-014 The block SHALL have port error  output  1  header word count exceeds DEPTH_WORDS.

Function
REQ-015 A byte SHALL transfer only on a clock edge where byte_valid and byte_ready are both 1.
REQ-016 The stream format SHALL be: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian.
REQ-017 The FSM SHALL have states HDR_LO, HDR_HI, DATA, WRITE, DONE and ERR.
REQ-018 byte_ready SHALL be 1 only in HDR_LO, HDR_HI and DATA.
REQ-019 Transitions: HDR_LO->HDR_HI on a byte; HDR_HI->DATA on a byte when 0<N<=DEPTH_WORDS; HDR_HI->DONE when N=0; HDR_HI->ERR when N>DEPTH_WORDS.
REQ-020 In DATA, the 4th byte of a word SHALL move the FSM to WRITE; WRITE SHALL last exactly one cycle.
REQ-021 InstrWrite SHALL be 1 only in WRITE, i.e. the cycle after the 4th byte is accepted (latency 1).
REQ-022 During WRITE, WriteInst SHALL carry the assembled word and WriteAdress SHALL be BASE_ADDR + 4*k, where k is the 0-based word index (32-bit wrap).
REQ-023 WRITE SHALL go to DATA if k+1<N, otherwise to DONE.
REQ-024 In DONE, core_reset SHALL be 0 and done SHALL be 1; in all other states core_reset SHALL be 1 and done SHALL be 0.
REQ-025 In ERR, error SHALL be 1 and core_reset SHALL stay 1; in all other states error SHALL be 0.
REQ-026 load_start in DONE or ERR SHALL go to HDR_LO and clear the byte and word counters; load_start in any other state SHALL be ignored.
REQ-027 A byte_valid gap inside a word SHALL stall assembly without losing accepted bytes.
REQ-028 WriteInst and WriteAdress SHALL hold their last values outside WRITE.

Reset
REQ-029 Asserting reset (0) SHALL immediately set: state HDR_LO, counters 0, byte_ready 1 after the reset edge handling, InstrWrite 0, WriteInst 0, WriteAdress BASE_ADDR, core_reset 1, done 0, error 0.
REQ-030 Reset asserted mid-load SHALL abandon the load; the next load SHALL restart at HDR_LO with word index 0.
REQ-031 Reset deassertion SHALL take effect on the next clk edge, with no partial byte retained.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum and the constants HDR_BYTES=2 and WORD_BYTES=4.
REQ-033 Sub-module word_assembler SHALL do the little-endian shift-in and the 2-bit byte counter, and SHALL assert word_full on the 4th byte.

Verification
REQ-034 Stream 02 00 13 00 00 00 93 00 10 00 with valid held high -> two InstrWrite pulses: 0x00000013@0x0, then 0x00100093@0x4; done=1, core_reset=0.
REQ-035 Header 00 00 -> DONE one cycle after the 2nd byte; InstrWrite never asserted.
REQ-036 Header 01 01 (N=257) with DEPTH_WORDS=256 -> ERR; error=1, byte_ready=0, core_reset=1, no writes.
REQ-037 byte_valid toggling 1/0 every cycle during data -> same words and addresses as REQ-034, with each strobe one cycle after the 4th accepted byte.
REQ-038 reset pulsed low after 5 bytes of REQ-034, then the full stream resent -> first write at 0x0 with 0x00000013, done=1.
REQ-039 load_start in DONE, then the REQ-034 stream with BASE_ADDR=0x100 -> writes at 0x100 and 0x104; core_reset=1 throughout the reload.
